// File: rtl/narnet_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : narnet_stream_feeder
// Desc     : FIFO-buffered sample sequencer in front of the NAR-Net core, with
//            per-sample timeout supervision and a valid/ready result stream.
// Revision : 1.0 - initial release
// ============================================================================
module narnet_stream_feeder #(
  parameter int N       = 8,
  parameter int Q       = 7,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [N-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [N-1:0]  x_in,
  output logic          x_ready,
  input  logic [N-1:0]  nn_y,
  input  logic          nn_out_ready,
  output logic [N-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   sample_cnt,
  output logic [AW:0]   fifo_level,
  output logic          timeout_err,
  input  logic          clr_err
);

  localparam int        c_DEPTH = 2 ** AW;
  localparam int        c_TW    = $clog2(TIMEOUT);
  localparam logic [AW:0]     c_FULL = (AW+1)'(c_DEPTH);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);

  // Q only documents the data format; the checks catch nonsensical builds.
  if (Q >= N) begin : g_bad_q
    $error("narnet_stream_feeder: Q must be smaller than N");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("narnet_stream_feeder: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_mem [c_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  logic              r_s_ready;
  logic [N-1:0]      r_x_in;
  logic [N-1:0]      r_m_data;
  logic              r_m_valid;
  logic [15:0]       r_sample_cnt;
  logic              r_timeout_err;
  logic [c_TW-1:0]   r_timer;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_expire;

  assign w_push = s_valid && r_s_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Only start when the core is quiet and the result slot can take a new value.
        if (enable && (r_count != '0) && !nn_out_ready && (!r_m_valid || m_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (nn_out_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == c_TMAX) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_ready <= 1'b1;
      r_x_in    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_x_in   <= r_mem[r_rd_ptr];
      end
      r_count   <= w_count_nxt;
      r_s_ready <= (w_count_nxt != c_FULL);
    end
  end

  // ---------------------------------------------------------------- result / supervision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer       <= '0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_sample_cnt  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timer <= (r_state == ST_WAIT) ? r_timer + c_TW'(1) : '0;
      if (w_capture) begin
        r_m_data     <= nn_y;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      if (w_capture) begin
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
      // A fresh expiry overrides a simultaneous clear.
      if (w_expire) begin
        r_timeout_err <= 1'b1;
      end else if (clr_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign fifo_level  = r_count;
  assign x_in        = r_x_in;
  assign x_ready     = (r_state == ST_ISSUE);
  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign sample_cnt  = r_sample_cnt;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_narnet_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_narnet_stream_feeder
// Desc     : Directed bench for narnet_stream_feeder with a simple core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_narnet_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  x_in;
  logic        x_ready;
  logic [7:0]  nn_y;
  logic        nn_out_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] sample_cnt;
  logic [4:0]  fifo_level;
  logic        timeout_err;
  logic        clr_err;

  int total = 0;
  int bad   = 0;
  int core_delay  = 3;
  int core_hold   = 0;
  bit core_silent = 1'b0;
  logic [7:0] issued[$];

  narnet_stream_feeder #(.N(8), .Q(7), .AW(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x_in(x_in), .x_ready(x_ready),
    .nn_y(nn_y), .nn_out_ready(nn_out_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .sample_cnt(sample_cnt), .fifo_level(fifo_level),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_xr(input string tag, input int budget);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!x_ready && i < budget);
    check(tag, x_ready, 1);
  endtask

  task automatic wait_cnt(input string tag, input logic [15:0] target, input int budget);
    int i = 0;
    while (sample_cnt != target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, sample_cnt, target);
  endtask

  task automatic wait_issues(input string tag, input int target, input int budget);
    int i = 0;
    while (issued.size() < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, issued.size(), target);
  endtask

  // Core model: answers x_in-4 core_delay cycles after x_ready, holding 1+core_hold cycles.
  initial begin
    nn_out_ready = 1'b0;
    nn_y         = '0;
    forever begin
      @(posedge clk); #1;
      if (x_ready && !core_silent) begin
        repeat (core_delay) @(posedge clk);
        #1;
        nn_y         = x_in - 8'h04;
        nn_out_ready = 1'b1;
        repeat (1 + core_hold) @(posedge clk);
        #1;
        nn_out_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (x_ready) issued.push_back(x_in);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b1; s_data = '0; s_valid = 1'b0;
    m_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_err", timeout_err, 0);
    check("rst_x_in", x_in, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single sample, exact latencies
    push(8'h40);
    @(negedge clk);
    check("t1_level", fifo_level, 1);
    check("t1_xr_early", x_ready, 0);
    @(negedge clk);
    check("t1_xr", x_ready, 1);
    check("t1_x_in", x_in, 8'h40);
    check("t1_level0", fifo_level, 0);
    repeat (3) @(negedge clk);
    check("t1_mv_early", m_valid, 0);
    @(negedge clk);
    check("t1_mv", m_valid, 1);
    check("t1_mdata", m_data, 8'h3C);
    check("t1_cnt", sample_cnt, 1);
    @(negedge clk);
    check("t1_one_issue", issued.size(), 1);

    // 2: fill FIFO with enable low, 17th push refused
    enable = 1'b0;
    issued.delete();
    for (int i = 0; i < 17; i++) begin
      s_data  = 8'h10 + 8'(i);
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("t2_full_ready", s_ready, 0);
    check("t2_full_level", fifo_level, 16);
    check("t2_no_issue", issued.size(), 0);
    enable = 1'b1;
    wait_issues("t2_issues", 16, 400);
    for (int i = 0; i < 16; i++) begin
      if (i < issued.size()) check("t2_order", issued[i], 8'h10 + 8'(i));
    end
    wait_cnt("t2_cnt", 16'd17, 50);
    repeat (10) @(negedge clk);
    check("t2_no_17th", issued.size(), 16);
    check("t2_level0", fifo_level, 0);
    check("t2_ready", s_ready, 1);

    // 3: back-pressure on the result stream blocks further issues
    m_ready = 1'b0;
    issued.delete();
    push(8'h21);
    push(8'h22);
    wait_cnt("t3_cnt1", 16'd18, 50);
    repeat (20) @(negedge clk);
    check("t3_blocked", issued.size(), 1);
    check("t3_mdata_hold", m_data, 8'h1D);
    check("t3_mvalid_hold", m_valid, 1);
    check("t3_level", fifo_level, 1);
    m_ready = 1'b1;
    wait_cnt("t3_cnt2", 16'd19, 50);
    check("t3_mdata2", m_data, 8'h1E);
    repeat (3) @(negedge clk);
    check("t3_issues", issued.size(), 2);
    check("t3_mvalid_clr", m_valid, 0);
    check("t3_x_in_hold", x_in, 8'h22);

    // 4: silent core, timeout, clear, set-beats-clear
    core_silent = 1'b1;
    push(8'h55);
    push(8'h66);
    wait_xr("t4_xr1", 20);
    check("t4_x_in1", x_in, 8'h55);
    repeat (64) @(negedge clk);
    check("t4_err_early", timeout_err, 0);
    @(negedge clk);
    check("t4_err", timeout_err, 1);
    check("t4_mvalid", m_valid, 0);
    @(negedge clk);
    check("t4_xr2", x_ready, 1);
    check("t4_x_in2", x_in, 8'h66);
    clr_err = 1'b1;
    repeat (64) @(negedge clk);
    check("t4_err_cleared", timeout_err, 0);
    @(negedge clk);
    check("t4_set_wins", timeout_err, 1);
    clr_err = 1'b0;
    @(negedge clk);
    check("t4_sticky", timeout_err, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t4_clr", timeout_err, 0);
    check("t4_cnt", sample_cnt, 19);
    core_silent = 1'b0;

    // 5: core holds out_ready for 2 extra cycles
    core_hold = 2;
    push(8'h30);
    push(8'h31);
    wait_xr("t5_xr1", 20);
    check("t5_x_in1", x_in, 8'h30);
    repeat (6) @(negedge clk);
    check("t5_cnt_once", sample_cnt, 20);
    check("t5_xr_held_off", x_ready, 0);
    @(negedge clk);
    check("t5_xr2", x_ready, 1);
    check("t5_x_in2", x_in, 8'h31);
    wait_cnt("t5_cnt2", 16'd21, 50);
    check("t5_mdata", m_data, 8'h2D);
    repeat (5) @(negedge clk);
    core_hold = 0;

    // 6: reset during WAIT with samples queued
    core_silent = 1'b1;
    enable = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    enable = 1'b1;
    wait_xr("t6_xr", 20);
    check("t6_x_in", x_in, 8'h01);
    repeat (2) @(negedge clk);
    check("t6_level5", fifo_level, 5);
    rst = 1'b0;
    #1;
    check("t6_level0", fifo_level, 0);
    check("t6_s_ready", s_ready, 1);
    check("t6_x_ready", x_ready, 0);
    check("t6_m_valid", m_valid, 0);
    check("t6_cnt", sample_cnt, 0);
    check("t6_x_in0", x_in, 0);
    @(negedge clk);
    rst = 1'b1;
    core_silent = 1'b0;
    @(negedge clk);
    issued.delete();
    push(8'h7F);
    wait_cnt("t6_cnt1", 16'd1, 50);
    check("t6_mdata", m_data, 8'h7B);
    check("t6_issued", issued.size(), 1);
    repeat (5) @(negedge clk);
    check("t6_level_end", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
